// File: rtl/mem_block_copier.sv
// Word-granular memory-to-memory copy engine with an Avalon-MM control slave.
// Streams one word per cycle from a 1-cycle-latency source memory into a destination memory.
module mem_block_copier #(
   parameter int DEPTH = 342,
   parameter int AW    = 9,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    ctrl_address,
   input  logic          ctrl_chipselect,
   input  logic          ctrl_write,
   input  logic          ctrl_read,
   input  logic [31:0]   ctrl_writedata,
   output logic [31:0]   ctrl_readdata,
   output logic          irq,
   output logic [AW-1:0] src_address,
   output logic          src_chipselect,
   input  logic [DW-1:0] src_readdata,
   output logic [AW-1:0] dst_address,
   output logic          dst_chipselect,
   output logic          dst_write,
   output logic [DW-1:0] dst_writedata,
   output logic [3:0]    dst_byteenable,
   output logic          src_clken,
   output logic          dst_clken
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [10:0] DEPTH_L = 11'(DEPTH);

   state_t        state;
   logic [AW-1:0] src_reg;
   logic [AW-1:0] dst_reg;
   logic [9:0]    len_reg;
   logic [9:0]    rd_cnt;
   logic [9:0]    wr_cnt;
   logic          busy;
   logic          done;
   logic          err;
   logic          valid;
   logic          reg_wr;
   logic          reg_rd;
   logic          go;
   logic          clear_done;
   logic [10:0]   src_end;
   logic [10:0]   dst_end;
   logic          unused_bits;

   assign reg_wr     = ctrl_chipselect & ctrl_write;
   assign reg_rd     = ctrl_chipselect & ctrl_read;
   assign go         = reg_wr && (ctrl_address == 2'd3) && ctrl_writedata[0];
   assign clear_done = reg_wr && (ctrl_address == 2'd3) && ctrl_writedata[1];
   assign src_end    = 11'(src_reg) + 11'(len_reg);
   assign dst_end    = 11'(dst_reg) + 11'(len_reg);
   assign unused_bits = ^ctrl_writedata;

   // Write side is driven straight off the delayed read-valid so returning data lands the same cycle.
   assign dst_chipselect = valid;
   assign dst_write      = valid;
   assign dst_address    = valid ? dst_reg + AW'(wr_cnt) : '0;
   assign dst_writedata  = valid ? src_readdata : '0;
   assign dst_byteenable = valid ? 4'hF : 4'h0;
   assign src_clken      = 1'b1;
   assign dst_clken      = 1'b1;
   assign irq            = done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         src_reg        <= '0;
         dst_reg        <= '0;
         len_reg        <= '0;
         rd_cnt         <= '0;
         wr_cnt         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         valid          <= 1'b0;
         src_chipselect <= 1'b0;
         src_address    <= '0;
      end else begin
         valid <= src_chipselect;
         if (reg_wr && !busy) begin
            case (ctrl_address)
               2'd0:    src_reg <= ctrl_writedata[AW-1:0];
               2'd1:    dst_reg <= ctrl_writedata[AW-1:0];
               2'd2:    len_reg <= ctrl_writedata[9:0];
               default: ;
            endcase
         end
         // clear_done is applied before any go so a combined write restarts cleanly.
         if (clear_done) done <= 1'b0;
         case (state)
            RUN: begin
               if (rd_cnt < len_reg) begin
                  src_chipselect <= 1'b1;
                  src_address    <= src_reg + AW'(rd_cnt);
                  rd_cnt         <= rd_cnt + 10'd1;
               end else begin
                  src_chipselect <= 1'b0;
               end
               if (valid) begin
                  wr_cnt <= wr_cnt + 10'd1;
                  if (wr_cnt == len_reg - 10'd1) begin
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state          <= IDLE;
               src_chipselect <= 1'b0;
               if (go) begin
                  if (len_reg == 10'd0) begin
                     done <= 1'b1;
                     err  <= 1'b0;
                  end else if (src_end > DEPTH_L || dst_end > DEPTH_L) begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end else begin
                     err    <= 1'b0;
                     done   <= 1'b0;
                     busy   <= 1'b1;
                     rd_cnt <= '0;
                     wr_cnt <= '0;
                     state  <= RUN;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_readdata <= '0;
      end else if (reg_rd) begin
         case (ctrl_address)
            2'd0:    ctrl_readdata <= 32'(src_reg);
            2'd1:    ctrl_readdata <= 32'(dst_reg);
            2'd2:    ctrl_readdata <= 32'(len_reg);
            default: ctrl_readdata <= {29'd0, err, done, busy};
         endcase
      end
   end

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: timing-based reference model plus per-cycle output comparison.
// Directed scenarios pin the model with literal values; a random loop exercises varied copies.
module tb_mem_block_copier;

   localparam int DEPTH = 342;
   localparam int AW    = 9;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    ctrl_address = '0;
   logic          ctrl_chipselect = 1'b0;
   logic          ctrl_write = 1'b0;
   logic          ctrl_read = 1'b0;
   logic [31:0]   ctrl_writedata = '0;
   logic [31:0]   ctrl_readdata;
   logic          irq;
   logic [AW-1:0] src_address;
   logic          src_chipselect;
   logic [DW-1:0] src_readdata = '0;
   logic [AW-1:0] dst_address;
   logic          dst_chipselect;
   logic          dst_write;
   logic [DW-1:0] dst_writedata;
   logic [3:0]    dst_byteenable;
   logic          src_clken;
   logic          dst_clken;

   mem_block_copier #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .ctrl_address(ctrl_address), .ctrl_chipselect(ctrl_chipselect),
      .ctrl_write(ctrl_write), .ctrl_read(ctrl_read),
      .ctrl_writedata(ctrl_writedata), .ctrl_readdata(ctrl_readdata), .irq(irq),
      .src_address(src_address), .src_chipselect(src_chipselect), .src_readdata(src_readdata),
      .dst_address(dst_address), .dst_chipselect(dst_chipselect), .dst_write(dst_write),
      .dst_writedata(dst_writedata), .dst_byteenable(dst_byteenable),
      .src_clken(src_clken), .dst_clken(dst_clken)
   );

   always #5 clk = ~clk;

   logic [31:0] src_mem [DEPTH];
   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Source memory with fixed one-cycle read latency.
   always @(posedge clk) if (src_chipselect) src_readdata <= src_mem[src_address];

   // Reference model: registers plus the start edge of the running copy.
   int          cyc = 0;
   int          t0 = 0;
   logic [8:0]  m_src = '0, m_dst = '0;
   logic [9:0]  m_len = '0;
   bit          m_busy = 0, m_done = 0, m_err = 0, m_act = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_src <= '0; m_dst <= '0; m_len <= '0;
         m_busy <= 0; m_done <= 0; m_err <= 0; m_act <= 0;
      end else begin
         if (ctrl_chipselect && ctrl_write && !m_busy) begin
            if (ctrl_address == 2'd0) m_src <= ctrl_writedata[8:0];
            if (ctrl_address == 2'd1) m_dst <= ctrl_writedata[8:0];
            if (ctrl_address == 2'd2) m_len <= ctrl_writedata[9:0];
         end
         if (ctrl_chipselect && ctrl_write && ctrl_address == 2'd3 && ctrl_writedata[1]) m_done <= 0;
         if (ctrl_chipselect && ctrl_write && ctrl_address == 2'd3 && ctrl_writedata[0] && !m_busy) begin
            if (m_len == 0) begin
               m_done <= 1; m_err <= 0;
            end else if (int'(m_src) + int'(m_len) > DEPTH || int'(m_dst) + int'(m_len) > DEPTH) begin
               m_done <= 1; m_err <= 1;
            end else begin
               m_done <= 0; m_err <= 0; m_busy <= 1; m_act <= 1; t0 <= cyc + 1;
            end
         end
         if (m_act && cyc + 1 == t0 + 2 + int'(m_len)) begin
            m_act <= 0; m_busy <= 0; m_done <= 1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int n_src = 0, n_dcs = 0, n_wr = 0;
   logic [8:0] last_addr = '0;
   logic [40:0] wq[$];

   always @(negedge clk) begin : cmp
      int  k;
      bit  es, ew;
      k  = cyc - t0;
      es = m_act && k >= 1 && k <= int'(m_len);
      ew = m_act && k >= 2 && k <= int'(m_len) + 1;
      if (chk_en) begin
         check("src_cs", src_chipselect, es);
         if (es) check("src_addr", src_address, m_src + k - 1);
         check("dst_write", dst_write, ew);
         check("dst_cs", dst_chipselect, ew);
         check("dst_be", dst_byteenable, ew ? 4'hF : 4'h0);
         if (ew) begin
            check("dst_addr", dst_address, m_dst + k - 2);
            check("dst_data", dst_writedata, src_mem[int'(m_src) + k - 2]);
         end
         check("irq", irq, m_done);
         check("clken", {src_clken, dst_clken}, 2'b11);
      end
      if (src_chipselect) n_src++;
      if (dst_chipselect) n_dcs++;
      if (dst_write) begin
         n_wr++;
         last_addr = dst_address;
         wq.push_back({dst_address, dst_writedata});
      end
   end

   task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
      ctrl_chipselect = 1; ctrl_write = 1; ctrl_address = a; ctrl_writedata = d;
      @(posedge clk); @(negedge clk);
      ctrl_chipselect = 0; ctrl_write = 0;
   endtask

   task automatic ctrl_rd(input logic [1:0] a, output logic [31:0] d);
      ctrl_chipselect = 1; ctrl_read = 1; ctrl_address = a;
      @(posedge clk); @(negedge clk);
      d = ctrl_readdata;
      ctrl_chipselect = 0; ctrl_read = 0;
   endtask

   task automatic check_csr(input string name);
      logic [31:0] exp, d;
      exp = {29'd0, m_err, m_done, m_busy};
      ctrl_rd(2'd3, d);
      check(name, d, exp);
   endtask

   task automatic setup(input int s, input int dd, input int l);
      ctrl_wr(2'd0, s); ctrl_wr(2'd1, dd); ctrl_wr(2'd2, l);
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (m_busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (m_busy) begin
         checks++; errors++;
         $display("FAIL wait_idle busy=1 after %0d cycles required=0", bound);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      for (int i = 0; i < DEPTH; i++) src_mem[i] = $urandom;
      repeat (3) @(negedge clk);
      reset = 0;
      check("rst_outs", {src_chipselect, dst_chipselect, dst_write, irq, dst_byteenable}, '0);
      check("rst_addr", {src_address, dst_address}, '0);
      check("rst_wdata", dst_writedata, '0);
      check("rst_rdata", ctrl_readdata, '0);
      check("rst_clken", {src_clken, dst_clken}, 2'b11);
      chk_en = 1;
      ctrl_rd(2'd0, d); check("rst_src", d, 0);
      ctrl_rd(2'd2, d); check("rst_len", d, 0);
      ctrl_rd(2'd3, d); check("rst_csr", d, 0);

      // Basic four-word copy with literal expectations.
      src_mem[0] = 32'h11; src_mem[1] = 32'h22; src_mem[2] = 32'h33; src_mem[3] = 32'h44;
      setup(0, 10, 4);
      wq.delete();
      ctrl_wr(2'd3, 32'h1);
      repeat (5) @(negedge clk);
      check("irq_t0p5", irq, 0);
      @(negedge clk);
      check("irq_t0p6", irq, 1);
      check("t1_nwr", wq.size(), 4);
      for (int i = 0; i < 4 && i < wq.size(); i++)
         check("t1_wr", wq[i], {9'(10 + i), 32'h11 * (i + 1)});
      ctrl_rd(2'd3, d); check("t1_csr", d, 32'h2);
      ctrl_wr(2'd3, 32'h2);
      check("clr_irq", irq, 0);
      ctrl_rd(2'd3, d); check("clr_csr", d, 32'h0);

      // Zero length: done only, no memory traffic.
      n_src = 0; n_dcs = 0;
      setup(5, 5, 0);
      ctrl_wr(2'd3, 32'h1);
      repeat (3) @(negedge clk);
      check("len0_src", n_src, 0);
      check("len0_dst", n_dcs, 0);
      ctrl_rd(2'd3, d); check("len0_csr", d, 32'h2);

      // Bounds: 343 rejected, 342 accepted.
      setup(300, 100, 43);
      ctrl_wr(2'd3, 32'h3);
      repeat (3) @(negedge clk);
      ctrl_rd(2'd3, d); check("oob_csr", d, 32'h6);
      check("oob_src", n_src, 0);
      check("oob_dst", n_dcs, 0);
      ctrl_wr(2'd0, 299);
      ctrl_wr(2'd3, 32'h3);
      wait_idle(100);
      check("edge_last", last_addr, 142);
      ctrl_rd(2'd3, d); check("edge_csr", d, 32'h2);

      // Writes while busy are ignored.
      setup(50, 200, 20);
      n_wr = 0;
      ctrl_wr(2'd3, 32'h3);
      repeat (4) @(negedge clk);
      ctrl_wr(2'd1, 5);
      ctrl_wr(2'd3, 32'h1);
      wait_idle(100);
      check("busy_nwr", n_wr, 20);
      check("busy_last", last_addr, 219);
      ctrl_rd(2'd1, d); check("busy_dst", d, 200);

      // Clear-and-go in one write.
      setup(7, 60, 12);
      ctrl_wr(2'd3, 32'h3);
      ctrl_rd(2'd3, d); check("cg_csr", d, 32'h1);
      wait_idle(100);
      ctrl_rd(2'd3, d); check("cg_done", d, 32'h2);

      // Reset in the cycle of write 7.
      setup(10, 30, 16);
      ctrl_wr(2'd3, 32'h3);
      repeat (9) @(posedge clk);
      #2;
      check("mid_wr7", {dst_write, dst_address}, {1'b1, 9'd37});
      reset = 1;
      #1;
      check("mid_strobes", {src_chipselect, dst_chipselect, dst_write}, 3'b000);
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      ctrl_rd(2'd3, d); check("mid_csr", d, 32'h0);
      check("mid_irq", irq, 0);
      ctrl_rd(2'd0, d); check("mid_src", d, 0);

      // Random copies, some out of bounds.
      for (int i = 0; i < 12; i++) begin
         int l, s, dd;
         l  = $urandom_range(40, 1);
         s  = $urandom_range(DEPTH - l, 0);
         dd = $urandom_range(DEPTH - l, 0);
         if (i % 4 == 3) s = DEPTH - l + 1;
         setup(s, dd, l);
         ctrl_wr(2'd3, (i % 2 == 1) ? 32'h3 : 32'h1);
         wait_idle(200);
         check_csr("rand_csr");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
